bird_collision_ctrl: RTL and testbench

- Downstream consumer of the bird position block's bird_x/bird_y.
- Each frame tick (bird_move), tests the bird box against the current pipe pair, the ground and the ceiling.
- Runs the game state machine (IDLE/PLAY/DEAD) and keeps the score.
- Outputs drive the renderer and the pipe scroller's enable.

---
 rtl/bird_collision_ctrl.sv | 135 +++++++++++++
 tb/tb_bird_collision_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bird_collision_ctrl.sv
// bird_collision_ctrl: per-frame bird/pipe/ground/ceiling collision test, IDLE/PLAY/DEAD game FSM and score keeping.
// Two-stage pipeline: geometry registered the cycle after a frame tick, FSM/score updated the cycle after that.
module bird_collision_ctrl #(
    parameter int BIRD_W    = 34,
    parameter int BIRD_H    = 24,
    parameter int PIPE_W    = 52,
    parameter int GAP_H     = 120,
    parameter int GROUND_Y  = 440,
    parameter int DEAD_HOLD = 60,
    parameter int SCORE_MAX = 999
) (
    input  logic        clk,
    input  logic        RESET_GAME,
    input  logic        bird_move,
    input  logic [3:0]  KEY,
    input  logic [10:0] bird_x,
    input  logic [10:0] bird_y,
    input  logic [10:0] pipe_x,
    input  logic [10:0] gap_y,
    output logic [1:0]  game_state,
    output logic        play_en,
    output logic        hit,
    output logic [9:0]  score
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;
    localparam int HW = $clog2(DEAD_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(DEAD_HOLD);
    localparam logic [9:0]  SMAX = 10'(SCORE_MAX);
    localparam logic [11:0] BW = 12'(BIRD_W);
    localparam logic [11:0] BH = 12'(BIRD_H);
    localparam logic [11:0] PW = 12'(PIPE_W);
    localparam logic [11:0] GH = 12'(GAP_H);
    localparam logic [11:0] GY = 12'(GROUND_Y);

    logic          bird_move_q, key3_q;
    logic [10:0]   pipe_x_prev_q, pipe_x_prev_d;
    logic          s1_valid_q, pipe_hit_q, ground_hit_q, ceil_hit_q, passed_q, wrapped_q;
    logic          pipe_hit_d, ground_hit_d, ceil_hit_d, passed_d, wrapped_d;
    logic [1:0]    state_q, state_d;
    logic          play_en_q, play_en_d, hit_q, hit_d, pass_armed_q, pass_armed_d;
    logic [9:0]    score_q, score_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          frame_tick, press, coll;
    logic [11:0]   bx, by, px, gy;
    logic          unused_keys;

    assign unused_keys = ^KEY[2:0];
    assign frame_tick  = bird_move & ~bird_move_q;
    assign press       = ~KEY[3] & key3_q;
    assign bx = {1'b0, bird_x};
    assign by = {1'b0, bird_y};
    assign px = {1'b0, pipe_x};
    assign gy = {1'b0, gap_y};

    always_comb begin
        pipe_hit_d    = (bx + BW > px) && (bx < px + PW) && ((by < gy) || (by + BH > gy + GH));
        ground_hit_d  = by + BH >= GY;
        ceil_hit_d    = by == 12'd0;
        passed_d      = px + PW < bx;
        wrapped_d     = pipe_x > pipe_x_prev_q;
        pipe_x_prev_d = frame_tick ? pipe_x : pipe_x_prev_q;
    end

    // Stage 2: a press seen while IDLE wins over any evaluation landing in the same cycle.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        hold_d       = hold_q;
        pass_armed_d = pass_armed_q;
        hit_d        = 1'b0;
        coll         = s1_valid_q && (pipe_hit_q || ground_hit_q || ceil_hit_q);
        if (state_q == S_PLAY) begin
            if (coll) begin
                state_d = S_DEAD;
                hit_d   = 1'b1;
                hold_d  = '0;
            end else if (s1_valid_q && passed_q && pass_armed_q) begin
                score_d      = (score_q >= SMAX) ? SMAX : score_q + 10'd1;
                pass_armed_d = 1'b0;
            end
        end else if (state_q == S_DEAD) begin
            if (press && hold_q == HOLD_MAX) state_d = S_IDLE;
            else if (frame_tick && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        end else if (press) begin
            state_d      = S_PLAY;
            score_d      = '0;
            pass_armed_d = 1'b1;
        end
        if (s1_valid_q && wrapped_q) pass_armed_d = 1'b1;
        play_en_d = state_d == S_PLAY;
    end

    always_ff @(posedge clk) begin
        if (RESET_GAME) begin
            bird_move_q   <= 1'b0;
            key3_q        <= 1'b1;
            pipe_x_prev_q <= '0;
            s1_valid_q    <= 1'b0;
            pipe_hit_q    <= 1'b0;
            ground_hit_q  <= 1'b0;
            ceil_hit_q    <= 1'b0;
            passed_q      <= 1'b0;
            wrapped_q     <= 1'b0;
            state_q       <= S_IDLE;
            play_en_q     <= 1'b0;
            hit_q         <= 1'b0;
            score_q       <= '0;
            hold_q        <= '0;
            pass_armed_q  <= 1'b1;
        end else begin
            bird_move_q   <= bird_move;
            key3_q        <= KEY[3];
            pipe_x_prev_q <= pipe_x_prev_d;
            s1_valid_q    <= frame_tick;
            pipe_hit_q    <= pipe_hit_d;
            ground_hit_q  <= ground_hit_d;
            ceil_hit_q    <= ceil_hit_d;
            passed_q      <= passed_d;
            wrapped_q     <= wrapped_d;
            state_q       <= state_d;
            play_en_q     <= play_en_d;
            hit_q         <= hit_d;
            score_q       <= score_d;
            hold_q        <= hold_d;
            pass_armed_q  <= pass_armed_d;
        end
    end

    assign game_state = state_q;
    assign play_en    = play_en_q;
    assign hit        = hit_q;
    assign score      = score_q;
endmodule

// File: tb/tb_bird_collision_ctrl.sv
// tb_bird_collision_ctrl: directed game scenarios plus randomized play, checked cycle by cycle against a frame-level game model.
module tb_bird_collision_ctrl;
    logic        clk = 1'b0;
    logic        RESET_GAME = 1'b1;
    logic        bird_move = 1'b0;
    logic [3:0]  KEY = 4'hF;
    logic [10:0] bird_x = 11'd100, bird_y = 11'd200, pipe_x = 11'd600, gap_y = 11'd150;
    logic [1:0]  game_state;
    logic        play_en, hit;
    logic [9:0]  score;

    bird_collision_ctrl dut (
        .clk(clk), .RESET_GAME(RESET_GAME), .bird_move(bird_move), .KEY(KEY),
        .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
        .game_state(game_state), .play_en(play_en), .hit(hit), .score(score)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int m_state, m_score, m_hold, m_prev_pipe;
    bit m_armed, m_hit, m_prev_move, m_prev_key;
    bit p_valid;
    int p_bx, p_by, p_px, p_gy, p_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advances the game by one clock using the rules on plain integers; a tick's geometry is judged one clock later.
    task automatic model_step();
        bit tick, press, coll, pass, wrap, release_ok;
        int top, bot;
        if (RESET_GAME) begin
            m_state = 0; m_score = 0; m_hold = 0; m_armed = 1; m_hit = 0;
            m_prev_move = 0; m_prev_key = 1; m_prev_pipe = 0; p_valid = 0;
            return;
        end
        tick  = bird_move && !m_prev_move;
        press = !KEY[3] && m_prev_key;
        coll = 0; pass = 0; wrap = 0;
        if (p_valid) begin
            top  = p_by;
            bot  = p_by + 24;
            coll = (p_bx + 34 > p_px && p_bx < p_px + 52 && (top < p_gy || bot > p_gy + 120)) || bot >= 440 || top == 0;
            pass = p_px + 52 < p_bx;
            wrap = p_px > p_prev;
        end
        m_hit = 0;
        if (m_state == 1) begin
            if (coll) begin m_state = 2; m_hit = 1; m_hold = 0; end
            else if (pass && m_armed) begin m_score = (m_score >= 999) ? 999 : m_score + 1; m_armed = 0; end
        end else if (m_state == 2) begin
            release_ok = press && m_hold == 60;
            if (tick && m_hold < 60) m_hold++;
            if (release_ok) m_state = 0;
        end else if (press) begin
            m_state = 1; m_score = 0; m_armed = 1;
        end
        if (wrap) m_armed = 1;
        p_valid = tick;
        if (tick) begin
            p_bx = bird_x; p_by = bird_y; p_px = pipe_x; p_gy = gap_y;
            p_prev = m_prev_pipe;
            m_prev_pipe = pipe_x;
        end
        m_prev_move = bird_move;
        m_prev_key  = KEY[3];
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("state", game_state, m_state);
        check("play_en", play_en, m_state == 1);
        check("hit", hit, m_hit);
        check("score", score, m_score);
    endtask

    task automatic tick();
        bird_move = 1'b1; step();
        bird_move = 1'b0; step();
    endtask

    task automatic press();
        KEY = 4'b0111; step();
        KEY = 4'hF;    step();
    endtask

    initial begin
        repeat (2) step();
        RESET_GAME = 1'b0;
        bird_y = 11'd0;
        repeat (10) tick();
        check("tp_idle_state", game_state, 0);
        check("tp_idle_score", score, 0);

        bird_y = 11'd200;
        KEY = 4'b0111; step();
        check("tp_start_state", game_state, 1);
        check("tp_start_play_en", play_en, 1);
        KEY = 4'hF; step();

        bird_x = 11'd100; pipe_x = 11'd120; gap_y = 11'd150;
        tick(); step();
        check("tp_in_gap", game_state, 1);
        bird_y = 11'd140;
        tick();
        check("tp_pipe_hit", hit, 1);
        check("tp_pipe_dead", game_state, 2);
        step();
        check("tp_hit_pulse_end", hit, 0);

        repeat (60) tick();
        press();
        check("tp_back_idle", game_state, 0);
        press();
        bird_y = 11'd420; pipe_x = 11'd600;
        tick();
        check("tp_ground_dead", game_state, 2);
        repeat (10) tick();
        press();
        check("tp_early_press", game_state, 2);
        repeat (50) tick();
        press();
        check("tp_release", game_state, 0);

        bird_y = 11'd200;
        press();
        pipe_x = 11'd60; tick();
        pipe_x = 11'd40; tick();
        check("tp_score1", score, 1);
        pipe_x = 11'd30; tick(); tick();
        check("tp_score_held", score, 1);
        pipe_x = 11'd600; tick();
        pipe_x = 11'd40; tick();
        check("tp_score2", score, 2);
        repeat (999) begin
            pipe_x = 11'd600; tick();
            pipe_x = 11'd40; tick();
        end
        check("tp_score_sat", score, 999);

        bird_move = 1'b1; RESET_GAME = 1'b1; step();
        RESET_GAME = 1'b0; bird_move = 1'b0; step(); step();
        check("tp_reset_state", game_state, 0);
        check("tp_reset_score", score, 0);
        press();
        bird_y = 11'd0;
        bird_move = 1'b1; step();
        bird_move = 1'b0; RESET_GAME = 1'b1; step();
        RESET_GAME = 1'b0; step();
        check("tp_reset_pipe_hit", hit, 0);
        step();
        check("tp_reset_pipe_state", game_state, 0);

        bird_y = 11'd200;
        for (int i = 0; i < 12000; i++) begin
            RESET_GAME = ($urandom_range(0, 999) == 0);
            bird_move  = ($urandom_range(0, 1) == 1);
            KEY        = {($urandom_range(0, 7) != 0), 3'b111};
            if ($urandom_range(0, 3) == 0) bird_x = 11'($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0) bird_y = 11'($urandom_range(0, 460));
            if ($urandom_range(0, 15) == 0) gap_y = 11'($urandom_range(20, 320));
            pipe_x = (pipe_x < 11'd12 || $urandom_range(0, 199) == 0) ? 11'($urandom_range(400, 700))
                                                                     : pipe_x - 11'($urandom_range(0, 8));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
